// File: rtl/sram_vector_reader_if.sv
// SRAM read-port bus and output word stream of the vector reader.
// master: the reader; slave: the SRAM plus the downstream consumer.
interface sram_vector_reader_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) ();
    logic [ADDR_W-1:0]   sram_address;
    logic                sram_chipselect;
    logic                sram_write;
    logic [DATA_W/8-1:0] sram_byteenable;
    logic [DATA_W-1:0]   sram_readdata;
    logic [DATA_W-1:0]   out_data;
    logic                out_valid;
    logic                out_ready;
    logic                out_last;

    modport master (
        output sram_address, sram_chipselect, sram_write, sram_byteenable,
        input  sram_readdata,
        output out_data, out_valid, out_last,
        input  out_ready
    );

    modport slave (
        input  sram_address, sram_chipselect, sram_write, sram_byteenable,
        output sram_readdata,
        input  out_data, out_valid, out_last,
        output out_ready
    );
endinterface

// File: rtl/sram_vector_reader.sv
// Fetches a contiguous vector from the operand SRAM read port and streams it
// out in order. A small capture FIFO absorbs the 1-cycle SRAM read latency;
// reads are only issued when a FIFO slot is guaranteed for the returning word.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | issuing reads and draining the FIFO to the stream
// DONE  | one-cycle completion pulse
module sram_vector_reader #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    sram_vector_reader_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0]  DEPTH_V = (CNT_W+1)'(FIFO_DEPTH);
    localparam logic [ADDR_W:0] ONE_V   = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   issue_cnt;
    logic [ADDR_W:0]   recv_cnt;
    logic              inflight;
    logic              issue;
    logic              push;
    logic              pop;
    logic [CNT_W:0]    post_pop;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  fifo_wr;
    logic [PTR_W-1:0]  fifo_rd;
    logic [CNT_W-1:0]  fifo_count;

    // Credit check: occupancy after this cycle's pop plus the word still in
    // flight must leave room for the word this cycle would request.
    always_comb begin
        push     = inflight;
        pop      = (fifo_count != '0) && bus.out_ready;
        post_pop = {1'b0, fifo_count} - {{CNT_W{1'b0}}, pop}
                 + {{CNT_W{1'b0}}, inflight};
        issue    = (state == FETCH) && (issue_cnt != '0) && (post_pop < DEPTH_V);
    end

    assign bus.sram_chipselect = issue;
    assign bus.sram_address    = rd_ptr;
    assign bus.sram_write      = 1'b0;
    assign bus.sram_byteenable = '1;
    assign bus.out_valid       = (fifo_count != '0);
    assign bus.out_data        = fifo_mem[fifo_rd];
    assign bus.out_last        = (fifo_count != '0) && (recv_cnt == ONE_V);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (length == '0) ? DONE : FETCH;
            FETCH:   if (pop && (recv_cnt == ONE_V)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status flags registered off the next state so they line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt == FETCH);
            done <= (state_nxt == DONE);
        end
    end

    // Address pointer and issue/receive counters; start only lands in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr    <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            inflight  <= 1'b0;
        end else begin
            inflight <= issue;
            if (state == IDLE && start) begin
                rd_ptr    <= base_addr;
                issue_cnt <= length;
                recv_cnt  <= length;
            end else begin
                if (issue) begin
                    rd_ptr    <= rd_ptr + 1'b1;
                    issue_cnt <= issue_cnt - ONE_V;
                end
                if (pop && recv_cnt != '0) recv_cnt <= recv_cnt - ONE_V;
            end
        end
    end

    // Capture FIFO: the word returns the cycle after its read was issued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_wr    <= '0;
            fifo_rd    <= '0;
            fifo_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            if (push) begin
                fifo_mem[fifo_wr] <= bus.sram_readdata;
                fifo_wr           <= fifo_wr + 1'b1;
            end
            if (pop) fifo_rd <= fifo_rd + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end
endmodule

// File: doc/sram_vector_reader.md
# sram_vector_reader

Read-side DMA stage for the NPU's 4096×16 dual-port operand SRAM. It drives the SRAM's second port, which is used as read-only, to fetch a contiguous vector of 16-bit words. It delivers those words in order on a valid/ready stream to the downstream MAC array. A small internal FIFO absorbs the SRAM's fixed 1-cycle read latency, so back-pressure never loses a word.

## Interface
Parameters:
- ADDR_W, 12, SRAM word-address width; the SRAM holds 2^ADDR_W words.
- DATA_W, 16, SRAM and stream data width.
- FIFO_DEPTH, 4, capture FIFO depth; power of two, minimum 2.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  sole clock; also clocks the SRAM port.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  single-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_W  first word address; latched on start.
- length  in  ADDR_W+1  word count, 0..4096; latched on start.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at transfer completion.
- sram_address  out  ADDR_W  read address to the SRAM second port.
- sram_chipselect  out  1  read strobe.
- sram_write  out  1  tied 0.
- sram_byteenable  out  DATA_W/8  tied all ones.
- sram_readdata  in  DATA_W  valid in the cycle after a strobed address.
- out_data  out  DATA_W  stream word.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready; a transfer occurs when out_valid and out_ready are both high.
- out_last  out  1  high with the final word of the vector.

## Operation
The block is a three-state FSM.

- IDLE
  - start=1 latches base_addr into rd_ptr and length into issue_cnt and recv_cnt, and sets busy.
  - If length=0, go to DONE. Otherwise go to FETCH.
- FETCH
  - Each cycle, issue a read (sram_chipselect=1, sram_address=rd_ptr) when both hold: issue_cnt>0, and fifo_count + inflight + 1 ≤ FIFO_DEPTH.
  - inflight is 1 if a read was issued in the previous cycle, otherwise 0.
  - On issue: rd_ptr increments modulo 2^ADDR_W (4095 wraps to 0), and issue_cnt decrements.
  - In the cycle after an issue, sram_readdata is pushed into the FIFO. The FIFO never overflows, by the credit rule above.
  - The FIFO head drives out_data and out_valid.
  - out_last = out_valid AND (recv_cnt = 1). recv_cnt decrements on each stream transfer.
  - When recv_cnt reaches 0 on a transfer, go to DONE.
- DONE
  - done=1 for exactly one cycle, busy falls in the same cycle, then go to IDLE.
- Rules that apply in every state:
  - start while busy is ignored; latched values are unchanged.
  - Simultaneous FIFO push and pop in one cycle is legal; fifo_count is unchanged.
  - out_data must stay stable while out_valid=1 and out_ready=0.
  - sram_write is always 0.
  - sram_chipselect=0 whenever no read is issued.
- Reset mid-transfer:
  - Return to IDLE immediately and empty the FIFO.
  - A pending read return is discarded.
  - No done pulse is produced.

## Timing
- Reset values:
  - busy=0, done=0, out_valid=0, out_last=0.
  - sram_chipselect=0, sram_address=0, out_data=0.
  - State is IDLE and all counters are 0.
- Start to first read:
  - start is sampled at clock edge E0.
  - The first read is issued in the cycle following E0 (sram_chipselect=1, sram_address=base_addr).
- Read data path:
  - The SRAM registers the address at E1.
  - The word is pushed into the FIFO at E2.
  - out_valid is high in the cycle after E2: 2 edges after start.
- Throughput: with out_ready held high, one word per cycle.
  - A vector of length N completes its last transfer at edge E(N+2).
  - done is high in the following cycle.
- Back-pressure:
  - Issuing stops while the credit check fails.
  - When out_ready rises, issuing resumes in the same cycle a pop frees a slot; the credit check uses the post-pop count.
- busy and done are registered outputs. out_valid, out_data and out_last come from FIFO registers; there is no combinational path from out_ready to the stream outputs.

## Test plan
- Basic read:
  - Stimulus: preload SRAM[i]=i+0x100; start with base=0x010, length=8, out_ready=1.
  - Response: words 0x110..0x117 in order; first out_valid 2 edges after start; out_last on 0x117; done one cycle later.
- Address wrap:
  - Stimulus: base=0xFFE, length=4.
  - Response: read addresses 0xFFE, 0xFFF, 0x000, 0x001; data in that order.
- Back-pressure:
  - Stimulus: length=16; out_ready toggles 1,0,0,1 repeating.
  - Response: all 16 words, no loss or duplication; never more than FIFO_DEPTH reads outstanding; out_data stable while stalled.
- Zero length:
  - Stimulus: start with length=0.
  - Response: no sram_chipselect; done pulses; busy returns to 0; no out_valid.
- Start ignored while busy:
  - Stimulus: second start during a length=8 transfer.
  - Response: ignored; exactly 8 words; single done.
- Reset mid-transfer:
  - Stimulus: assert reset after 3 words accepted.
  - Response: all outputs at reset values immediately (asynchronously); a new start with length=2 then yields exactly 2 correct words.
